// File: rtl/cordic_pkg.sv
// Shared constants for the cordic vectoring pipeline and its magnitude post-processing.
// The inverse gain is derived from the gain itself so the two stay consistent.
package cordic_pkg;

    localparam int  ITERATIONS  = 14;
    localparam int  XY_BITS     = 16;
    localparam int  XY_W        = XY_BITS + 1;
    localparam int  CORDIC_LAT  = ITERATIONS + 1;
    localparam int  MAG_W       = 16;
    localparam int  WINDOW      = 8;

    localparam real CORDIC_GAIN = 1.6467602581210654;
    localparam int  GAIN_FRAC   = 15;
    // 1/CORDIC_GAIN in unsigned Q0.GAIN_FRAC, rounded to nearest (19898)
    localparam int  INV_GAIN    = $rtoi((2.0 ** GAIN_FRAC) / CORDIC_GAIN + 0.5);

endpackage

// File: rtl/mag_peak_window.sv
// Windowed peak detector: tracks the maximum over every WINDOW valid magnitudes
// and emits it with a one-cycle pulse when the window completes.
module mag_peak_window #(
    parameter int MAG_W  = cordic_pkg::MAG_W,
    parameter int WINDOW = cordic_pkg::WINDOW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [MAG_W-1:0] in_mag,
    output logic             peak_valid,
    output logic [MAG_W-1:0] peak
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAG_W-1:0] runmax_q, runmax_d;
    logic [MAG_W-1:0] peak_q, peak_d;
    logic             peak_valid_q, peak_valid_d;
    logic [MAG_W-1:0] base;
    logic [MAG_W-1:0] cand;

    always_comb begin
        // runmax is meaningless at the first sample of a window
        base         = (cnt_q == '0) ? '0 : runmax_q;
        cand         = (in_mag > base) ? in_mag : base;
        cnt_d        = cnt_q;
        runmax_d     = runmax_q;
        peak_d       = peak_q;
        peak_valid_d = 1'b0;
        if (in_valid) begin
            if (cnt_q == CNT_W'(WINDOW - 1)) begin
                peak_d       = cand;
                peak_valid_d = 1'b1;
                cnt_d        = '0;
                runmax_d     = '0;
            end else begin
                runmax_d = cand;
                cnt_d    = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            runmax_q     <= '0;
            peak_q       <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            runmax_q     <= runmax_d;
            peak_q       <= peak_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak       = peak_q;

endmodule

// File: rtl/cordic_mag_post.sv
// Aligns a sample-valid with the cordic x_o, removes the CORDIC gain, rounds and
// saturates to a true magnitude, and reports a windowed peak of those magnitudes.
module cordic_mag_post #(
    parameter int XY_W       = cordic_pkg::XY_W,
    parameter int CORDIC_LAT = cordic_pkg::CORDIC_LAT,
    parameter int INV_GAIN   = cordic_pkg::INV_GAIN,
    parameter int MAG_W      = cordic_pkg::MAG_W,
    parameter int WINDOW     = cordic_pkg::WINDOW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [XY_W-1:0]  cordic_x,
    output logic             mag_valid,
    output logic [MAG_W-1:0] mag,
    output logic             peak_valid,
    output logic [MAG_W-1:0] peak
);

    localparam int GF   = cordic_pkg::GAIN_FRAC;
    localparam int P1_W = XY_W + GF;
    localparam int R_W  = XY_W + 1;

    localparam logic [P1_W-1:0] GAIN_EXT = P1_W'(INV_GAIN);
    localparam logic [P1_W:0]   HALF     = (P1_W + 1)'(1) << (GF - 1);
    localparam logic [R_W-1:0]  MAG_MAX  = R_W'((1 << MAG_W) - 1);

    logic                  vin_q, vin_d;
    logic [CORDIC_LAT-1:0] vld_sr_q, vld_sr_d;
    logic                  tap;
    logic [P1_W-1:0]       p1_q, p1_d;
    logic                  v1_q, v1_d;
    logic [MAG_W-1:0]      mag_q, mag_d;
    logic                  mag_valid_q, mag_valid_d;
    logic [P1_W:0]         p1_rnd;
    logic [R_W-1:0]        r;

    always_comb begin
        // vin_q mirrors the cordic input capture register, so the tap lines up with x_o
        vin_d       = in_valid;
        vld_sr_d    = {vld_sr_q[CORDIC_LAT-2:0], vin_q};
        tap         = vld_sr_q[CORDIC_LAT-1];
        p1_d        = tap ? (P1_W'(cordic_x) * GAIN_EXT) : p1_q;
        v1_d        = tap;
        p1_rnd      = {1'b0, p1_q} + HALF;
        r           = p1_rnd[P1_W:GF];
        mag_d       = mag_q;
        if (v1_q) begin
            mag_d = (r > MAG_MAX) ? '1 : r[MAG_W-1:0];
        end
        mag_valid_d = v1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vin_q       <= 1'b0;
            vld_sr_q    <= '0;
            p1_q        <= '0;
            v1_q        <= 1'b0;
            mag_q       <= '0;
            mag_valid_q <= 1'b0;
        end else begin
            vin_q       <= vin_d;
            vld_sr_q    <= vld_sr_d;
            p1_q        <= p1_d;
            v1_q        <= v1_d;
            mag_q       <= mag_d;
            mag_valid_q <= mag_valid_d;
        end
    end

    assign mag_valid = mag_valid_q;
    assign mag       = mag_q;

    mag_peak_window #(
        .MAG_W  (MAG_W),
        .WINDOW (WINDOW)
    ) u_peak (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (mag_valid_q),
        .in_mag     (mag_q),
        .peak_valid (peak_valid),
        .peak       (peak)
    );

endmodule

// File: tb/tb_cordic_mag_post.sv
// Randomized bench for cordic_mag_post with a queue-based reference model of
// magnitudes, arrival cycles and window peaks.
module tb_cordic_mag_post;
    import cordic_pkg::*;

    localparam int L = CORDIC_LAT;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [XY_W-1:0]  cordic_x = '0;
    logic             mag_valid;
    logic [MAG_W-1:0] mag;
    logic             peak_valid;
    logic [MAG_W-1:0] peak;

    cordic_mag_post dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .cordic_x   (cordic_x),
        .mag_valid  (mag_valid),
        .mag        (mag),
        .peak_valid (peak_valid),
        .peak       (peak)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    typedef struct {
        int val;
        int due;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t mq[$];
    exp_t pq[$];
    int   win_mags[$];
    int   last_mag  = 0;
    int   last_peak = 0;
    bit   vin_h[int];
    int   xin_h[int];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    // True magnitude of a raw cordic x: x * 0.607239 rounded half-up, clipped to 16 bits
    function automatic int mag_ref(input int x);
        longint r;
        r = (longint'(x) * 19898 + 16384) / 32768;
        return (r > 65535) ? 65535 : int'(r);
    endfunction

    function automatic int x_for(input int m);
        int x0;
        x0 = (m * 32768) / 19898;
        for (int d = -3; d <= 3; d++)
            if (x0 + d >= 0 && mag_ref(x0 + d) == m) return x0 + d;
        return x0;
    endfunction

    task automatic monitor();
        int  e;
        bit  exp_mv;
        bit  exp_pv;
        int  mx;
        e      = edge_no;
        exp_mv = (mq.size() > 0) && (mq[0].due == e);
        check("mag_valid", mag_valid, exp_mv);
        if (exp_mv) begin
            check("mag", mag, mq[0].val);
            last_mag = mq[0].val;
            win_mags.push_back(mq[0].val);
            if (win_mags.size() == WINDOW) begin
                mx = 0;
                foreach (win_mags[i]) if (win_mags[i] > mx) mx = win_mags[i];
                pq.push_back('{mx, e + 1});
                win_mags.delete();
            end
            void'(mq.pop_front());
        end else if (!mag_valid) begin
            check("mag_hold", mag, last_mag);
        end
        exp_pv = (pq.size() > 0) && (pq[0].due == e);
        check("peak_valid", peak_valid, exp_pv);
        if (exp_pv) begin
            check("peak", peak, pq[0].val);
            last_peak = pq[0].val;
            void'(pq.pop_front());
        end else begin
            check("peak_hold", peak, last_peak);
        end
    endtask

    // One cycle: check outputs of the last edge, then drive the next input
    task automatic tick(input bit v, input int x);
        int e;
        int src;
        @(negedge clk);
        monitor();
        e        = edge_no;
        vin_h[e] = v;
        xin_h[e] = x;
        in_valid = v;
        src      = e - L - 1;
        if (vin_h.exists(src) && vin_h[src]) cordic_x = XY_W'(xin_h[src]);
        else cordic_x = XY_W'($urandom);
        if (v) mq.push_back('{mag_ref(x), e + L + 3});
    endtask

    task automatic drain(input int n);
        repeat (n) tick(1'b0, 0);
    endtask

    task automatic model_reset();
        mq.delete();
        pq.delete();
        win_mags.delete();
        last_mag  = 0;
        last_peak = 0;
    endtask

    int win1[8] = '{10, 50, 20, 50, 5, 7, 9, 3};
    int sx[4]   = '{53972, 131071, 0, 1};
    int sm[4]   = '{32774, 65535, 0, 1};

    initial begin
        repeat (2) @(negedge clk);
        check("rst_mag_valid", mag_valid, 0);
        check("rst_mag", mag, 0);
        check("rst_peak_valid", peak_valid, 0);
        check("rst_peak", peak, 0);
        rst = 1'b0;

        foreach (win1[i]) begin
            tick(1'b1, x_for(win1[i]));
            if (i % 3 == 1) drain(2);
        end
        drain(L + 5);
        check("win1_peak", peak, 50);
        for (int m = 1; m <= 8; m++) tick(1'b1, x_for(m));
        drain(L + 5);
        check("win2_peak", peak, 8);

        foreach (sx[i]) begin
            tick(1'b1, sx[i]);
            drain(L + 4);
            check("single_mag", mag, sm[i]);
        end

        repeat (20) tick(1'b1, int'($urandom_range(0, 131071)));
        drain(L + 4);

        repeat (300) tick(1'b1 & $urandom_range(0, 1), int'($urandom_range(0, 131071)));
        drain(L + 4);

        // Bring the window to exactly 3 accumulated samples, then put 5 in flight
        while (win_mags.size() != 3) begin
            tick(1'b1, int'($urandom_range(0, 131071)));
            drain(L + 4);
        end
        repeat (5) tick(1'b1, int'($urandom_range(0, 131071)));
        #2 rst = 1'b1;
        #1;
        check("arst_mag_valid", mag_valid, 0);
        check("arst_mag", mag, 0);
        check("arst_peak_valid", peak_valid, 0);
        check("arst_peak", peak, 0);
        model_reset();
        drain(2);
        rst = 1'b0;
        drain(L + 6);

        repeat (8) tick(1'b1, int'($urandom_range(0, 131071)));
        drain(L + 5);

        repeat (200) tick(1'b1 & $urandom_range(0, 1), int'($urandom_range(0, 131071)));
        drain(L + 5);
        check("mag_queue_empty", mq.size(), 0);
        check("peak_queue_empty", pq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
